// File: rtl/decode_pkg.sv
// Shared RV32I/RV64I decode constants: opcodes, func7 values, immediate-format codes
// and the ALU/branch/load/store codes the execute stage also uses.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ADD = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  localparam logic [2:0] ST_B = 3'b000;
  localparam logic [2:0] ST_H = 3'b001;
  localparam logic [2:0] ST_W = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage handshake bundle: upstream valid/ready + instruction, downstream
// valid/ready + decoded fields. The stage itself uses the slave modport.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_rd,
           out_rs1, out_rs2, out_imm, out_imm_type, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_func3, out_func7, out_rd,
           out_rs1, out_rs2, out_imm, out_imm_type, out_pc, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the format from the opcode and
// sign-extends the assembled immediate to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type
);

  logic [31:0] raw_s;

  // Assemble a 32-bit sign-extended immediate, then widen it to XLEN.
  always_comb begin
    raw_s    = 32'h0000_0000;
    imm_type = IMM_NONE;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        raw_s    = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OPC_STORE: begin
        raw_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        raw_s    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OPC_JAL: begin
        raw_s    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw_s    = {instr[31:12], 12'h000};
        imm_type = IMM_U;
      end
      default: begin
        raw_s    = 32'h0000_0000;
        imm_type = IMM_NONE;
      end
    endcase
  end

  assign imm = {{(XLEN-31){raw_s[31]}}, raw_s[30:0]};

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake and a one-entry skid.
// Illegal-instruction checking is built only when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  logic [XLEN-1:0] imm_s;
  logic [2:0]      imm_type_s;
  logic            illegal_s;
  logic            accept_s;
  logic            out_free_s;

  logic            out_valid_r;
  logic [31:0]     out_instr_r;
  logic [PC_W-1:0] out_pc_r;
  logic [XLEN-1:0] out_imm_r;
  logic [2:0]      out_type_r;
  logic            out_illegal_r;

  logic            skid_valid_r;
  logic [31:0]     skid_instr_r;
  logic [PC_W-1:0] skid_pc_r;
  logic [XLEN-1:0] skid_imm_r;
  logic [2:0]      skid_type_r;
  logic            skid_illegal_r;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (bus.in_instr),
    .imm      (imm_s),
    .imm_type (imm_type_s)
  );

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Shift-immediates only allow shamt bits up to log2(XLEN); the rest must be 0 or the SRAI marker.
  function automatic logic check_illegal(input logic [31:0] instr);
    logic       bad;
    logic [6:0] hi;
    logic [6:0] sra_code;
    bad      = 1'b0;
    hi       = (XLEN == 64) ? {1'b0, instr[31:26]} : instr[31:25];
    sra_code = (XLEN == 64) ? 7'h10 : 7'h20;
    if (instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: bad = 1'b0;
        OPC_OP: bad = !((instr[31:25] == F7_ADD) ||
                        ((instr[31:25] == F7_SUB) &&
                         ((instr[14:12] == F3_ADD) || (instr[14:12] == F3_SR))));
        OPC_OP_IMM: begin
          if (instr[14:12] == F3_SLL) begin
            bad = (hi != 7'h00);
          end else if (instr[14:12] == F3_SR) begin
            bad = !((hi == 7'h00) || (hi == sra_code));
          end else begin
            bad = 1'b0;
          end
        end
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  assign illegal_s = check_illegal(bus.in_instr);
`else
  assign illegal_s = 1'b0;
`endif

  assign bus.in_ready = ~skid_valid_r;
  assign accept_s     = bus.in_valid & ~skid_valid_r & ~flush;
  assign out_free_s   = ~out_valid_r | bus.out_ready;

  // Output register and skid entry; skid drains first so order stays FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      out_valid_r    <= 1'b0;
      out_instr_r    <= 32'h0000_0000;
      out_pc_r       <= '0;
      out_imm_r      <= '0;
      out_type_r     <= IMM_NONE;
      out_illegal_r  <= 1'b0;
      skid_valid_r   <= 1'b0;
      skid_instr_r   <= 32'h0000_0000;
      skid_pc_r      <= '0;
      skid_imm_r     <= '0;
      skid_type_r    <= IMM_NONE;
      skid_illegal_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_valid_r   <= 1'b1;
        out_instr_r   <= skid_instr_r;
        out_pc_r      <= skid_pc_r;
        out_imm_r     <= skid_imm_r;
        out_type_r    <= skid_type_r;
        out_illegal_r <= skid_illegal_r;
        skid_valid_r  <= 1'b0;
      end else if (accept_s) begin
        out_valid_r   <= 1'b1;
        out_instr_r   <= bus.in_instr;
        out_pc_r      <= bus.in_pc;
        out_imm_r     <= imm_s;
        out_type_r    <= imm_type_s;
        out_illegal_r <= illegal_s;
      end else begin
        out_valid_r   <= 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_r   <= 1'b1;
      skid_instr_r   <= bus.in_instr;
      skid_pc_r      <= bus.in_pc;
      skid_imm_r     <= imm_s;
      skid_type_r    <= imm_type_s;
      skid_illegal_r <= illegal_s;
    end
  end

  assign bus.out_valid    = out_valid_r;
  assign bus.out_opcode   = out_instr_r[6:0];
  assign bus.out_func3    = out_instr_r[14:12];
  assign bus.out_func7    = out_instr_r[31:25];
  assign bus.out_rd       = out_instr_r[11:7];
  assign bus.out_rs1      = out_instr_r[19:15];
  assign bus.out_rs2      = out_instr_r[24:20];
  assign bus.out_imm      = out_imm_r;
  assign bus.out_imm_type = out_type_r;
  assign bus.out_pc       = out_pc_r;
  assign bus.out_illegal  = out_illegal_r;

endmodule
